muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the Execute stage of the 5-stage MIPS pipeline. It replaces the single-cycle ALU mult path and the unintegrated divider. It produces the 2*WIDTH HI/LO result for the M-stage hilo register, and drives a stall handshake that freezes F/D/E while an operation is in flight. It also supports annulment on an M-stage exception.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.
MUL_STAGES, 2, multiply latency in cycles after acceptance; legal range is 1..8.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  request an operation; held high by the pipeline while E is stalled.
op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
annul_i  in  1  abort the current or requested operation; driven by the exception flush (|excepttypeM).
a_i  in  WIDTH  operand A (dividend / multiplicand), forwarded E-stage rs value.
b_i  in  WIDTH  operand B (divisor / multiplier), forwarded E-stage rt value.
result_o  out  2*WIDTH  {HI, LO}.
  - Multiply: HI:LO is the full product.
  - Divide: HI is the remainder and LO is the quotient.
ready_o  out  1  one-cycle pulse; result_o is valid in this cycle.
stall_o  out  1  stall request to the hazard unit.
busy_o  out  1  an operation is in flight (state MUL or DIV).

Behaviour:
- Reset: state=IDLE. result_o=0, ready_o=0, stall_o=0, busy_o=0. Counters and operand registers are cleared. Reset during any state aborts immediately; no ready_o pulse is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE, when start_i=1 and annul_i=0, the unit accepts in cycle T0:
  - It latches operands and op.
  - For signed ops it latches absolute values plus the sign bits.
  - MULT/MULTU goes to MUL with counter=MUL_STAGES-1.
  - DIV/DIVU with b_i!=0 goes to DIV with counter=WIDTH-1.
  - DIV/DIVU with b_i==0 goes to DONE directly.
- MUL: the product is computed over MUL_STAGES registered stages. Retiming of the multiplier is allowed; the latency is fixed. When counter==0 the unit goes to DONE; otherwise it decrements the counter.
- DIV: radix-2 restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits wide. When counter==0 the unit goes to DONE; otherwise it decrements the counter.
- DONE: result_o is updated on entry. ready_o=1 for exactly this cycle, then the unit returns to IDLE. start_i is ignored in DONE, because it still belongs to the completed instruction.
- Latency:
  - Multiply: ready_o is high in cycle T0+MUL_STAGES+1.
  - Divide: ready_o is high in cycle T0+WIDTH+1.
  - Divide by zero: ready_o is high in cycle T0+1.
- stall_o (combinational) = ~annul_i & ((state==IDLE & start_i) | state==MUL | state==DIV). It is 0 in DONE, so the pipeline advances in the ready cycle.
- busy_o=1 in MUL and DIV only.
- Signed fix-up, applied on DONE entry:
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
  - MULT product is negated if sign(a)^sign(b).
  - Arithmetic is modulo 2^WIDTH per half.
- Overflow case: DIV of the most-negative value by -1 gives LO=most-negative value and HI=0, with no exception.
- Divide by zero, both signed and unsigned: LO={WIDTH{1'b1}}, HI=a_i as latched, no exception.
- Annul:
  - annul_i=1 in any cycle of MUL or DIV makes the unit go to IDLE on the next edge.
  - No ready_o pulse is produced and result_o keeps its previous value.
  - stall_o is 0 in the annul cycle.
  - annul_i in IDLE blocks acceptance.
  - annul_i in DONE has no effect on the already-updated result_o.
  - A new start_i is accepted in the cycle after annulment.
- result_o holds the last completed value until the next DONE. It is never cleared except by rst.
- Back-to-back operations: after the DONE cycle, the next start_i seen in IDLE is a new instruction. There is no bubble requirement beyond this IDLE cycle.

Test Plan:
1. WIDTH=32, MUL_STAGES=2; MULT a=0xFFFFFFFF, b=2 at T0.
   - ready_o must pulse at T3 with result_o=0xFFFFFFFF_FFFFFFFE.
   - stall_o must be 1 in T0..T2 and 0 in T3.
   - The same operands with MULTU must give 0x00000001_FFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7), b=2 at T0.
   - ready_o must be 1 only at T33, with LO=0xFFFFFFFD and HI=0xFFFFFFFF.
   - busy_o must be 1 in T1..T32.
3. DIVU a=100, b=0.
   - ready_o must be 1 at T1 with result_o=0x00000064_FFFFFFFF.
   - DIV a=0x80000000, b=0xFFFFFFFF must give result_o=0x00000000_80000000.
4. DIVU 50/7 is started.
   - annul_i=1 at T10 must give stall_o=0 at T10, no ready_o, and result_o unchanged.
   - A MULTU 3*5 started at T11 must pulse ready_o at T14 with result 15.
5. rst is asserted asynchronously mid-DIV at T5. All outputs must go to 0 immediately and the unit must accept a new start after rst is released.
6. start_i is held high through DONE. Exactly one ready_o pulse must occur per operation, and no re-acceptance may happen in the DONE cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply and restoring divide for the E stage
// Produces {HI, LO}, a one-cycle ready pulse and a stall request; annulled by M-stage exceptions.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o,
  output logic                 busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = $clog2((WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES) + 1;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH:0]       r_rem;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH+1:0]     w_shift;
  logic [WIDTH+1:0]     w_diff;
  logic [WIDTH:0]       w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_sel;
  logic [2*WIDTH-1:0]   w_prod_fin;

  assign w_signed = ~op_i[0];
  assign w_abs_a  = (w_signed & a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_abs_b  = (w_signed & b_i[WIDTH-1]) ? -b_i : b_i;

  // r_a doubles as the dividend shift register; quotient bits enter at the LSB.
  assign w_shift    = {r_rem, r_a[WIDTH-1]};
  assign w_diff     = w_shift - {2'b00, r_b};
  assign w_rem_next = w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
  assign w_quo_next = {r_a[WIDTH-2:0], ~w_diff[WIDTH+1]};
  assign w_quo_fix  = r_neg_res ? -w_quo_next : w_quo_next;
  assign w_rem_fix  = r_neg_rem ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];

  assign w_prod     = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_prod_fin = r_neg_res ? -w_prod_sel : w_prod_sel;

  generate
    if (MUL_STAGES == 1) begin : g_comb
      assign w_prod_sel = w_prod;
    end else begin : g_pipe
      logic [2*WIDTH-1:0] r_pipe [0:MUL_STAGES-2];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < MUL_STAGES - 1; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= w_prod;
          for (int k = 1; k < MUL_STAGES - 1; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign w_prod_sel = r_pipe[MUL_STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_a       <= w_abs_a;
            r_b       <= w_abs_b;
            r_rem     <= '0;
            r_neg_res <= w_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg_rem <= w_signed & a_i[WIDTH-1];
            if (!op_i[1]) begin
              r_state <= S_MUL;
              r_cnt   <= CW'(MUL_STAGES - 1);
            end else if (b_i == '0) begin
              r_state  <= S_DONE;
              r_result <= {a_i, {WIDTH{1'b1}}};
            end else begin
              r_state <= S_DIV;
              r_cnt   <= CW'(WIDTH - 1);
            end
          end
        end
        S_MUL: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_result <= w_prod_fin;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_a   <= w_quo_next;
            if (r_cnt == '0) begin
              r_state  <= S_DONE;
              r_result <= {w_rem_fix, w_quo_fix};
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = (r_state == S_DONE);
  assign busy_o   = (r_state == S_MUL) | (r_state == S_DIV);
  assign stall_o  = ~rst & ~annul_i &
                    (((r_state == S_IDLE) & start_i) | (r_state == S_MUL) | (r_state == S_DIV));

endmodule
